// File: rtl/avalon_mem_bank_arbiter_if.sv
// Avalon-MM burst bus bundle. N_PORTS lanes are packed side by side (lane i = slice i);
// readdata is shared by all lanes, everything else is per lane.
interface avalon_mem_bank_arbiter_if #(
  parameter int N_PORTS         = 1,
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [N_PORTS*ADDR_WIDTH-1:0]      address;
  logic [N_PORTS*BURST_CNT_WIDTH-1:0] burstcount;
  logic [N_PORTS-1:0]                 read;
  logic [N_PORTS-1:0]                 write;
  logic [N_PORTS*DATA_WIDTH-1:0]      writedata;
  logic [N_PORTS*BE_WIDTH-1:0]        byteenable;
  logic [N_PORTS-1:0]                 waitrequest;
  logic [DATA_WIDTH-1:0]              readdata;
  logic [N_PORTS-1:0]                 readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_mem_bank_arbiter.sv
// Round-robin arbiter sharing one burst-capable Avalon-MM memory bank among N_REQ requesters.
// Write bursts keep the grant until their last beat; read responses are routed via an in-order tag FIFO.
module avalon_mem_bank_arbiter #(
  parameter int N_REQ           = 4,
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int RD_FIFO_DEPTH   = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  avalon_mem_bank_arbiter_if.slave         req,
  avalon_mem_bank_arbiter_if.master        avm,
  output logic [$clog2(RD_FIFO_DEPTH):0]   rd_outstanding
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int ID_WIDTH  = $clog2(N_REQ);
  localparam int PTR_WIDTH = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  typedef enum logic {ARB, WBURST} state_t;

  state_t                     state_reg, state_next;
  logic [ID_WIDTH-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [ID_WIDTH-1:0]        gnt_id_reg, gnt_id_next;
  logic [BURST_CNT_WIDTH-1:0] beats_left_reg, beats_left_next;

  logic [ID_WIDTH-1:0]        tag_id_mem    [RD_FIFO_DEPTH];
  logic [BURST_CNT_WIDTH-1:0] tag_beats_mem [RD_FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CNT_WIDTH-1:0]       count_reg;
  logic [BURST_CNT_WIDTH-1:0] rsp_beats_reg;

  logic [ADDR_WIDTH-1:0]      req_addr  [N_REQ];
  logic [BURST_CNT_WIDTH-1:0] req_bc    [N_REQ];
  logic [DATA_WIDTH-1:0]      req_wdata [N_REQ];
  logic [BE_WIDTH-1:0]        req_be    [N_REQ];
  logic [N_REQ-1:0]           req_active;

  logic [ID_WIDTH-1:0]        gnt;
  logic                       gnt_valid;
  logic                       gnt_is_read;
  logic                       gnt_is_write;
  logic [BURST_CNT_WIDTH-1:0] gnt_bc;
  logic                       fifo_full;
  logic                       rd_block;
  logic                       stall_gnt;
  logic                       avm_read_int;
  logic                       avm_write_int;
  logic                       rd_accept;
  logic                       wr_accept;
  logic                       cmd_accept;
  logic [ID_WIDTH-1:0]        head_id;
  logic [BURST_CNT_WIDTH-1:0] head_beats;
  logic                       rsp_valid;
  logic                       rsp_last;
  logic [N_REQ-1:0]           wait_vec;
  logic [N_REQ-1:0]           rdv_vec;

  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_WIDTH'(s);
  endfunction

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign req_addr[gi]   = req.address[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_bc[gi]     = req.burstcount[gi*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
    assign req_wdata[gi]  = req.writedata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_be[gi]     = req.byteenable[gi*BE_WIDTH +: BE_WIDTH];
    assign req_active[gi] = req.read[gi] | req.write[gi];
  end

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    gnt       = rr_ptr_reg;
    gnt_valid = 1'b0;
    if (state_reg == WBURST) begin
      gnt       = gnt_id_reg;
      gnt_valid = req.write[gnt_id_reg];
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req_active[wrap_add(rr_ptr_reg, i)]) begin
          gnt       = wrap_add(rr_ptr_reg, i);
          gnt_valid = 1'b1;
        end
      end
    end
  end

  // Reads take precedence over a simultaneous write from the same requester; never during a burst.
  assign gnt_is_read   = (state_reg == ARB) && req.read[gnt];
  assign gnt_is_write  = req.write[gnt] && !gnt_is_read;
  assign gnt_bc        = req_bc[gnt];
  assign fifo_full     = (count_reg == CNT_WIDTH'(RD_FIFO_DEPTH));
  assign rd_block      = gnt_valid && gnt_is_read && fifo_full;
  assign stall_gnt     = avm.waitrequest[0] | rd_block;

  assign avm_read_int  = reset_n && gnt_valid && gnt_is_read && !rd_block;
  assign avm_write_int = reset_n && gnt_valid && gnt_is_write;
  assign rd_accept     = avm_read_int && !avm.waitrequest[0];
  assign wr_accept     = avm_write_int && !avm.waitrequest[0];
  assign cmd_accept    = rd_accept || wr_accept;

  assign avm.read       = avm_read_int;
  assign avm.write      = avm_write_int;
  assign avm.address    = req_addr[gnt];
  assign avm.burstcount = gnt_bc;
  assign avm.writedata  = req_wdata[gnt];
  assign avm.byteenable = req_be[gnt];

  assign head_id    = tag_id_mem[rd_ptr_reg];
  assign head_beats = tag_beats_mem[rd_ptr_reg];
  assign rsp_valid  = reset_n && avm.readdatavalid[0] && (count_reg != '0);
  assign rsp_last   = rsp_valid && (rsp_beats_reg == head_beats - BURST_CNT_WIDTH'(1));

  always_comb begin
    wait_vec = '1;
    rdv_vec  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (reset_n && gnt_valid && (gnt == ID_WIDTH'(i))) wait_vec[i] = stall_gnt;
      if (rsp_valid && (head_id == ID_WIDTH'(i)))        rdv_vec[i]  = 1'b1;
    end
  end

  assign req.waitrequest   = wait_vec;
  assign req.readdatavalid = rdv_vec;
  assign req.readdata      = avm.readdata;
  assign rd_outstanding    = reset_n ? count_reg : '0;

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    gnt_id_next     = gnt_id_reg;
    beats_left_next = beats_left_reg;
    case (state_reg)
      ARB: begin
        if (rd_accept || (wr_accept && gnt_bc <= BURST_CNT_WIDTH'(1))) begin
          rr_ptr_next = wrap_add(gnt, 1);
        end else if (wr_accept) begin
          gnt_id_next     = gnt;
          beats_left_next = gnt_bc - BURST_CNT_WIDTH'(1);
          state_next      = WBURST;
        end
      end
      WBURST: begin
        if (wr_accept) begin
          beats_left_next = beats_left_reg - BURST_CNT_WIDTH'(1);
          if (beats_left_reg == BURST_CNT_WIDTH'(1)) begin
            rr_ptr_next = wrap_add(gnt_id_reg, 1);
            state_next  = ARB;
          end
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ARB;
      rr_ptr_reg     <= '0;
      gnt_id_reg     <= '0;
      beats_left_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      rsp_beats_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      gnt_id_reg     <= gnt_id_next;
      beats_left_reg <= beats_left_next;
      if (rd_accept) wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
      if (rsp_last)  rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
      case ({rd_accept, rsp_last})
        2'b10:   count_reg <= count_reg + CNT_WIDTH'(1);
        2'b01:   count_reg <= count_reg - CNT_WIDTH'(1);
        default: count_reg <= count_reg;
      endcase
      // Beats received so far for the head entry; restarts when the head is popped.
      if (rsp_valid) rsp_beats_reg <= rsp_last ? '0 : rsp_beats_reg + BURST_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      tag_id_mem[wr_ptr_reg]    <= gnt;
      tag_beats_mem[wr_ptr_reg] <= gnt_bc;
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n)
                   (cmd_accept && state_reg == ARB) |-> (gnt_bc != '0));

endmodule

// File: tb/tb_avalon_mem_bank_arbiter.sv
// Directed bench for avalon_mem_bank_arbiter: per-requester driver agents, a bank-side
// responder driven from the main sequence, and a scoreboard of expected commands and read routes.
module tb_avalon_mem_bank_arbiter;
  localparam int N_REQ = 4;
  localparam int AW    = 27;
  localparam int DW    = 512;
  localparam int BCW   = 7;
  localparam int DEPTH = 16;
  localparam int BEW   = DW / 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  avalon_mem_bank_arbiter_if #(.N_PORTS(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW)) req_bus ();
  avalon_mem_bank_arbiter_if #(.N_PORTS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW)) avm_bus ();
  logic [$clog2(DEPTH):0] rd_outstanding;

  avalon_mem_bank_arbiter #(
    .N_REQ(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW), .RD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req_bus),
    .avm(avm_bus),
    .rd_outstanding(rd_outstanding)
  );

  typedef struct {
    bit             rd;
    logic [AW-1:0]  addr;
    logic [BCW-1:0] bc;
  } cmd_t;

  typedef struct {
    bit             rd;
    logic [AW-1:0]  addr;
    logic [BCW-1:0] bc;
    logic [31:0]    wd;
    logic [BEW-1:0] be;
  } exp_t;

  cmd_t agent_q [N_REQ][$];
  exp_t cmd_q[$];
  int   rsp_q[$];
  int   acc_cyc_q[$];
  bit   flush = 1'b0;
  bit   agent_busy [N_REQ];

  logic           a_rd   [N_REQ];
  logic           a_wr   [N_REQ];
  logic [AW-1:0]  a_addr [N_REQ];
  logic [BCW-1:0] a_bc   [N_REQ];
  logic [31:0]    a_wd   [N_REQ];
  logic [DW-1:0]  bank_rdata;
  int             rd_seq = 0;

  function automatic logic [31:0] wd_of(input logic [AW-1:0] a, input int beat);
    return {a[23:0], 8'(beat)};
  endfunction

  function automatic logic [BEW-1:0] be_of(input int i);
    return {(BEW/8){8'(17 * (i + 1))}};
  endfunction

  function automatic logic [AW-1:0] addr_of(input int id, input int seq);
    return AW'(id * 'h10000 + seq);
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bus.read[i]                      = a_rd[i];
      req_bus.write[i]                     = a_wr[i];
      req_bus.address[i*AW +: AW]          = a_addr[i];
      req_bus.burstcount[i*BCW +: BCW]     = a_bc[i];
      req_bus.writedata[i*DW +: DW]        = {(DW/32){a_wd[i]}};
      req_bus.byteenable[i*BEW +: BEW]     = be_of(i);
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester agents: hold each command/beat until accepted, then present the next one.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_agent
    cmd_t cur;
    int   beat;
    bit   busy;
    bit   acc;
    initial begin
      busy = 1'b0; beat = 0; acc = 1'b0;
      cur.rd = 1'b0; cur.addr = '0; cur.bc = '0;
      agent_busy[gi] = 1'b0;
      a_rd[gi] = 1'b0; a_wr[gi] = 1'b0; a_addr[gi] = '0; a_bc[gi] = '0; a_wd[gi] = '0;
      forever begin
        @(negedge clk);
        acc = (a_rd[gi] || a_wr[gi]) && !req_bus.waitrequest[gi] && reset_n;
        @(posedge clk);
        #1;
        if (flush) begin
          agent_q[gi].delete();
          busy = 1'b0;
        end else if (acc) begin
          if (cur.rd) busy = 1'b0;
          else begin
            beat++;
            if (beat >= int'(cur.bc)) busy = 1'b0;
          end
        end
        if (!busy && !flush && agent_q[gi].size() > 0) begin
          cur  = agent_q[gi].pop_front();
          busy = 1'b1;
          beat = 0;
        end
        agent_busy[gi] = busy;
        a_rd[gi]   = busy && cur.rd;
        a_wr[gi]   = busy && !cur.rd;
        a_addr[gi] = cur.addr;
        a_bc[gi]   = cur.bc;
        a_wd[gi]   = wd_of(cur.addr, beat);
      end
    end
  end

  // Scoreboard monitor: bank-side commands and requester-side read routing.
  always @(negedge clk) begin
    exp_t e;
    int   id;
    if (reset_n && (avm_bus.read[0] || avm_bus.write[0]) && !avm_bus.waitrequest[0]) begin
      acc_cyc_q.push_back(cyc);
      if (cmd_q.size() == 0) begin
        check("cmd_unexpected", {avm_bus.read[0], avm_bus.write[0]}, '0);
      end else begin
        e = cmd_q.pop_front();
        check("cmd_type", {avm_bus.read[0], avm_bus.write[0]}, e.rd ? 2'b10 : 2'b01);
        check("cmd_addr", avm_bus.address, e.addr);
        check("cmd_bc", avm_bus.burstcount, e.bc);
        check("cmd_be", avm_bus.byteenable, e.be);
        if (!e.rd) check("cmd_wdata", avm_bus.writedata, {(DW/32){e.wd}});
      end
    end
    if (|req_bus.readdatavalid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", req_bus.readdatavalid, '0);
      end else begin
        id = rsp_q.pop_front();
        check("rsp_route", req_bus.readdatavalid, N_REQ'(1) << id);
        check("rsp_data", req_bus.readdata, bank_rdata);
      end
    end
  end

  task automatic issue(input int id, input bit rd, input int seq, input int bc);
    cmd_t c;
    c.rd = rd; c.addr = addr_of(id, seq); c.bc = BCW'(bc);
    agent_q[id].push_back(c);
  endtask

  task automatic expect_cmd(input int id, input bit rd, input int seq, input int bc);
    exp_t e;
    e.rd = rd; e.addr = addr_of(id, seq); e.bc = BCW'(bc); e.be = be_of(id); e.wd = '0;
    if (rd) begin
      cmd_q.push_back(e);
      for (int k = 0; k < bc; k++) rsp_q.push_back(id);
    end else begin
      for (int b = 0; b < bc; b++) begin
        e.wd = wd_of(e.addr, b);
        cmd_q.push_back(e);
      end
    end
  endtask

  function automatic bit agents_idle();
    for (int i = 0; i < N_REQ; i++)
      if (agent_busy[i] || agent_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      #1;
      if (cmd_q.size() == 0 && agents_idle()) break;
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $error("FAIL %s timeout observed=busy expected=idle", tag);
    end
  endtask

  task automatic drive_beat();
    bank_rdata = {(DW/32){32'hD00D0000 + 32'(rd_seq)}};
    rd_seq++;
    avm_bus.readdata = bank_rdata;
    avm_bus.readdatavalid = 1'b1;
  endtask

  task automatic bank_return(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      drive_beat();
    end
    @(posedge clk);
    #1;
    avm_bus.readdatavalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    avm_bus.waitrequest   = 1'b0;
    avm_bus.readdata      = '0;
    avm_bus.readdatavalid = 1'b1;
    bank_rdata            = '0;

    // Reset state, with a stray readdatavalid on the bank side.
    repeat (2) @(negedge clk);
    check("rst_wait", req_bus.waitrequest, 4'hF);
    check("rst_rdv", req_bus.readdatavalid, '0);
    check("rst_outstanding", rd_outstanding, '0);
    check("rst_avm_cmd", {avm_bus.read[0], avm_bus.write[0]}, '0);
    @(posedge clk); #1;
    avm_bus.readdatavalid = 1'b0;
    reset_n = 1'b1;

    // 1: simultaneous single reads from req0 and req2.
    @(negedge clk);
    acc_cyc_q.delete();
    issue(0, 1, 1, 1); issue(2, 1, 1, 1);
    expect_cmd(0, 1, 1, 1); expect_cmd(2, 1, 1, 1);
    wait_idle("t1_issue", 20);
    check("t1_outstanding", rd_outstanding, 2);
    check("t1_back_to_back", acc_cyc_q.size() == 2 ? acc_cyc_q[1] - acc_cyc_q[0] : -1, 1);
    bank_return(2);
    @(negedge clk);
    check("t1_rsp_drained", rsp_q.size(), 0);
    check("t1_outstanding_end", rd_outstanding, 0);

    // 2: req1 4-beat write burst while req0 reads (prelude moves rr_ptr to 1).
    @(negedge clk);
    issue(0, 0, 2, 1); expect_cmd(0, 0, 2, 1);
    wait_idle("t2_prelude", 20);
    acc_cyc_q.delete();
    issue(1, 0, 2, 4); issue(0, 1, 3, 1);
    expect_cmd(1, 0, 2, 4); expect_cmd(0, 1, 3, 1);
    wait_idle("t2_issue", 30);
    check("t2_accepts", acc_cyc_q.size(), 5);
    check("t2_burst_span", acc_cyc_q.size() == 5 ? acc_cyc_q[3] - acc_cyc_q[0] : -1, 3);
    check("t2_read_after", acc_cyc_q.size() == 5 ? acc_cyc_q[4] - acc_cyc_q[3] : -1, 1);
    bank_return(1);
    @(negedge clk);
    check("t2_rsp_drained", rsp_q.size(), 0);

    // 3: req3 fills the tag FIFO; the 17th read waits for a pop.
    @(negedge clk);
    for (int s = 0; s < 17; s++) begin
      issue(3, 1, 16 + s, 1);
      expect_cmd(3, 1, 16 + s, 1);
    end
    n = 0;
    while (cmd_q.size() > 1 && n < 60) begin @(negedge clk); #1; n++; end
    if (n >= 60) begin
      checks++; failures++;
      $error("FAIL t3_fill timeout observed=%0d expected=1", cmd_q.size());
    end
    repeat (3) @(negedge clk);
    check("t3_full_count", rd_outstanding, 16);
    check("t3_read_blocked", avm_bus.read[0], 1'b0);
    check("t3_req3_stalled", req_bus.waitrequest[3], 1'b1);
    @(posedge clk); #1;
    drive_beat();
    @(negedge clk);
    check("t3_no_bypass", avm_bus.read[0], 1'b0);
    check("t3_count_pop_cycle", rd_outstanding, 16);
    @(posedge clk); #1;
    avm_bus.readdatavalid = 1'b0;
    @(negedge clk);
    check("t3_read_after_pop", avm_bus.read[0], 1'b1);
    check("t3_count_after_pop", rd_outstanding, 15);
    wait_idle("t3_last", 20);
    check("t3_full_again", rd_outstanding, 16);
    bank_return(16);
    @(negedge clk);
    check("t3_rsp_drained", rsp_q.size(), 0);
    check("t3_outstanding_end", rd_outstanding, 0);

    // 4: burst reads (2 beats to req0, 3 to req1) issued behind a bank stall.
    @(posedge clk); #1;
    avm_bus.waitrequest = 1'b1;
    @(negedge clk);
    issue(0, 1, 40, 2); issue(1, 1, 40, 3);
    expect_cmd(0, 1, 40, 2); expect_cmd(1, 1, 40, 3);
    @(negedge clk);
    check("t4_stall_wait", req_bus.waitrequest, 4'hF);
    check("t4_stall_addr", avm_bus.address, addr_of(0, 40));
    check("t4_stall_read", avm_bus.read[0], 1'b1);
    @(posedge clk); #1;
    avm_bus.waitrequest = 1'b0;
    wait_idle("t4_issue", 20);
    check("t4_outstanding", rd_outstanding, 2);
    bank_return(5);
    @(negedge clk);
    check("t4_rsp_drained", rsp_q.size(), 0);
    check("t4_outstanding_end", rd_outstanding, 0);

    // 5: reset in the middle of a write burst with three reads outstanding.
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      issue(2, 1, 50 + s, 1);
      expect_cmd(2, 1, 50 + s, 1);
    end
    wait_idle("t5_reads", 20);
    check("t5_outstanding", rd_outstanding, 3);
    issue(1, 0, 60, 4); expect_cmd(1, 0, 60, 4);
    n = 0;
    while (cmd_q.size() > 2 && n < 30) begin @(negedge clk); #1; n++; end
    if (n >= 30) begin
      checks++; failures++;
      $error("FAIL t5_beat2 timeout observed=%0d expected=2", cmd_q.size());
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    flush = 1'b1;
    drive_beat();
    @(negedge clk);
    check("t5_write_gated", avm_bus.write[0], 1'b0);
    check("t5_wait_all", req_bus.waitrequest, 4'hF);
    check("t5_rdv_gated", req_bus.readdatavalid, '0);
    check("t5_outstanding_rst", rd_outstanding, '0);
    cmd_q.delete();
    rsp_q.delete();
    @(posedge clk); #2;
    avm_bus.readdatavalid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    flush = 1'b0;
    @(posedge clk); #1;
    drive_beat();
    @(negedge clk);
    check("t5_late_rdv_dropped", req_bus.readdatavalid, '0);
    check("t5_outstanding_after", rd_outstanding, '0);
    @(posedge clk); #1;
    avm_bus.readdatavalid = 1'b0;
    @(negedge clk);
    issue(3, 1, 70, 1); expect_cmd(3, 1, 70, 1);
    wait_idle("t5_post_reset_read", 20);
    check("t5_post_outstanding", rd_outstanding, 1);
    bank_return(1);
    @(negedge clk);
    check("t5_rsp_drained", rsp_q.size(), 0);

    // 6: all four requesters stream single writes; strict rotation from rr_ptr = 0.
    @(negedge clk);
    acc_cyc_q.delete();
    for (int r = 0; r < 10; r++)
      for (int id = 0; id < N_REQ; id++) begin
        issue(id, 0, 100 + r, 1);
        expect_cmd(id, 0, 100 + r, 1);
      end
    wait_idle("t6_stream", 100);
    check("t6_accepts", acc_cyc_q.size(), 40);
    check("t6_span", acc_cyc_q.size() == 40 ? acc_cyc_q[39] - acc_cyc_q[0] : -1, 39);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
